// File: rtl/md_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes,
// FSM state encoding and a small decode helper.
package md_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // DIV and REM treat their operands as two's complement.
  function automatic logic md_div_signed(input logic [2:0] f);
    return f[2] & ~f[0];
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per
// cycle. quotient/remainder show the values after the current cycle's step.
module md_div_core
  import md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [XLEN:0]   trial;

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    // trial[XLEN] set means the shifted remainder is below the divisor.
    trial  = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
    if (abort) begin
      quo_d  = '0;
      rem_d  = '0;
      dvs_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (start) begin
      quo_d  = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (!trial[XLEN]) rem_d = trial[XLEN-1:0];
      else              rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
      quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(XLEN-1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign quotient  = quo_d;
  assign remainder = rem_d;

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit in EX. Handshake: an op is accepted in IDLE when
// md_valid & ~md_kill; md_stall holds EX until md_done, which persists while md_hold.
module ex_muldiv
  import md_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 1
) (
  input  logic            clk,
  input  logic            cpurst,
  input  logic            md_valid,
  input  logic [2:0]      md_funct3,
  input  logic [XLEN-1:0] md_op1,
  input  logic [XLEN-1:0] md_op2,
  input  logic            md_kill,
  input  logic            md_hold,
  output logic            md_stall,
  output logic [XLEN-1:0] md_result,
  output logic            md_done
);

  localparam int CW = $clog2(XLEN);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, result_q, result_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            done_q, done_d;
  logic            stall_c;

  logic            div_start, div_busy;
  logic [XLEN-1:0] div_dividend, div_divisor, div_quo, div_rem;
  logic            in_sgn, in_zero, in_ovf, neg_q, neg_r;
  logic [XLEN:0]   mul_a, mul_b;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0] mul_sel, div_sel;

  // Incoming divide operands reduced to magnitudes before the core sees them.
  assign in_sgn       = md_div_signed(md_funct3);
  assign div_dividend = (in_sgn && md_op1[XLEN-1]) ? -md_op1 : md_op1;
  assign div_divisor  = (in_sgn && md_op2[XLEN-1]) ? -md_op2 : md_op2;
  assign in_zero      = (md_op2 == '0);
  assign in_ovf       = in_sgn && (md_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (md_op2 == '1);

  assign mul_a   = {((funct3_q == MD_MULH) || (funct3_q == MD_MULHSU)) & op1_q[XLEN-1], op1_q};
  assign mul_b   = {(funct3_q == MD_MULH) & op2_q[XLEN-1], op2_q};
  assign product = (2*XLEN)'($signed(mul_a) * $signed(mul_b));
  assign mul_sel = (funct3_q == MD_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  assign neg_q   = md_div_signed(funct3_q) & (op1_q[XLEN-1] ^ op2_q[XLEN-1]);
  assign neg_r   = md_div_signed(funct3_q) & op1_q[XLEN-1];
  assign div_sel = funct3_q[1] ? (neg_r ? -div_rem : div_rem)
                               : (neg_q ? -div_quo : div_quo);

  md_div_core #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (cpurst),
    .start     (div_start),
    .abort     (md_kill),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .busy      (div_busy),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    funct3_d  = funct3_q;
    result_d  = result_q;
    done_d    = 1'b0;
    div_start = 1'b0;
    stall_c   = 1'b0;
    if (md_kill) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      result_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (md_valid) begin
            stall_c  = 1'b1;
            op1_d    = md_op1;
            op2_d    = md_op2;
            funct3_d = md_funct3;
            cnt_d    = '0;
            if (!md_funct3[2]) begin
              state_d = ST_MUL;
            end else if (in_zero) begin
              state_d  = ST_DONE;
              done_d   = 1'b1;
              result_d = md_funct3[1] ? md_op1 : '1;
            end else if (in_ovf) begin
              state_d  = ST_DONE;
              done_d   = 1'b1;
              result_d = md_funct3[1] ? '0 : md_op1;
            end else begin
              state_d   = ST_DIV;
              div_start = 1'b1;
            end
          end
        end
        ST_MUL: begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(MUL_LAT-1)) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = mul_sel;
            cnt_d    = '0;
          end
        end
        ST_DIV: begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          // The core's busy flag is a backstop should the two counters ever disagree.
          if ((cnt_q == CW'(XLEN-1)) || !div_busy) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = div_sel;
            cnt_d    = '0;
          end
        end
        ST_DONE: begin
          if (md_hold) done_d = 1'b1;
          else         state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cpurst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      funct3_q <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      funct3_q <= funct3_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign md_stall  = stall_c & ~cpurst;
  assign md_result = result_q;
  assign md_done   = done_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M corner cases, hold/kill/reset
// scenarios and randomized ops against a plain-arithmetic reference model.
module tb_ex_muldiv;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 1;

  logic            clk, cpurst, md_valid, md_kill, md_hold;
  logic [2:0]      md_funct3;
  logic [XLEN-1:0] md_op1, md_op2, md_result;
  logic            md_stall, md_done;

  int total = 0;
  int bad   = 0;
  logic [XLEN-1:0] exp_q[$];

  ex_muldiv #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .cpurst    (cpurst),
    .md_valid  (md_valid),
    .md_funct3 (md_funct3),
    .md_op1    (md_op1),
    .md_op2    (md_op2),
    .md_kill   (md_kill),
    .md_hold   (md_hold),
    .md_stall  (md_stall),
    .md_result (md_result),
    .md_done   (md_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: RV32M semantics with 64-bit integer arithmetic.
  function automatic logic [XLEN-1:0] ref_md(input logic [2:0] f, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, pu;
    logic [63:0] w;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; w = p; return w[31:0]; end
      3'd1: begin p = sa * sb; w = p; return w[63:32]; end
      3'd2: begin p = sa * longint'(ub); w = p; return w[63:32]; end
      3'd3: begin pu = ua * ub; w = pu; return w[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (ovf) return a;
        p = sa / sb; w = p; return w[31:0];
      end
      3'd5: begin
        if (b == 0) return '1;
        pu = ua / ub; w = pu; return w[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return '0;
        p = sa % sb; w = p; return w[31:0];
      end
      default: begin
        if (b == 0) return a;
        pu = ua % ub; w = pu; return w[31:0];
      end
    endcase
  endfunction

  // Cycles in EX from acceptance through the DONE cycle.
  function automatic int ref_lat(input logic [2:0] f, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
    if (!f[2]) return MUL_LAT + 2;
    if (b == 0) return 2;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return XLEN + 2;
  endfunction

  // Driver: present one op, follow it to DONE, optionally hold, then retire it.
  task automatic run_op(input logic [2:0] f, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input int hold_cycles);
    int cyc, stalls, lat;
    logic [XLEN-1:0] exp;
    logic seen;
    exp_q.push_back(ref_md(f, a, b));
    lat = ref_lat(f, a, b);
    @(negedge clk);
    md_valid  = 1'b1;
    md_funct3 = f;
    md_op1    = a;
    md_op2    = b;
    #1;
    cyc    = 1;
    stalls = 0;
    seen   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (md_done) begin
        seen = 1'b1;
        break;
      end
      if (md_stall) stalls++;
      @(negedge clk);
      #1;
      cyc++;
    end
    exp = exp_q.pop_front();
    if (!seen) begin
      check("done_timeout", 32'(0), 32'(1));
      md_valid = 1'b0;
      return;
    end
    check($sformatf("result_f%0d", f), md_result, exp);
    check("done_cycle", 32'(cyc), 32'(lat));
    check("stall_cycles", 32'(stalls), 32'(lat - 1));
    check("stall_in_done", 32'(md_stall), 32'(0));
    for (int h = 0; h < hold_cycles; h++) begin
      md_hold = 1'b1;
      @(negedge clk);
      #1;
      check("hold_done", 32'(md_done), 32'(1));
      check("hold_result", md_result, exp);
      check("hold_no_restart", 32'(md_stall), 32'(0));
    end
    md_hold = 1'b0;
    @(negedge clk);
    md_valid = 1'b0;
    #1;
    check("retire_done", 32'(md_done), 32'(0));
    check("retire_stall", 32'(md_stall), 32'(0));
  endtask

  // Start a DIV and interrupt it at cnt=10 with kill (use_reset=0) or reset.
  task automatic abort_div(input logic use_reset);
    @(negedge clk);
    md_valid  = 1'b1;
    md_funct3 = 3'd4;
    md_op1    = 32'd1000;
    md_op2    = 32'd3;
    repeat (11) @(negedge clk);
    if (use_reset) cpurst = 1'b1;
    else           md_kill = 1'b1;
    #1;
    check(use_reset ? "rst_cycle_stall" : "kill_cycle_stall", 32'(md_stall), 32'(0));
    @(negedge clk);
    cpurst   = 1'b0;
    md_kill  = 1'b0;
    md_valid = 1'b0;
    #1;
    check(use_reset ? "rst_after_stall" : "kill_after_stall", 32'(md_stall), 32'(0));
    check(use_reset ? "rst_after_done" : "kill_after_done", 32'(md_done), 32'(0));
    if (use_reset) check("rst_after_result", md_result, 32'(0));
    repeat (3) @(negedge clk);
    #1;
    check("abort_no_residual_done", 32'(md_done), 32'(0));
  endtask

  function automatic logic [XLEN-1:0] pick_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    cpurst    = 1'b1;
    md_valid  = 1'b0;
    md_kill   = 1'b0;
    md_hold   = 1'b0;
    md_funct3 = 3'd0;
    md_op1    = '0;
    md_op2    = '0;
    repeat (3) @(negedge clk);
    cpurst = 1'b0;
    #1;
    check("rst_done", 32'(md_done), 32'(0));
    check("rst_result", md_result, 32'(0));
    check("rst_stall", 32'(md_stall), 32'(0));

    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'd4, -32'd7, 32'd2, 0);
    run_op(3'd6, -32'd7, 32'd2, 0);
    run_op(3'd5, 32'd5, 32'd0, 0);
    run_op(3'd7, 32'd5, 32'd0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd5, 32'd100, 32'd7, 3);
    run_op(3'd0, 32'd12, 32'd11, 3);

    abort_div(1'b0);
    run_op(3'd5, 32'd100, 32'd7, 0);
    abort_div(1'b1);
    run_op(3'd5, 32'd100, 32'd7, 0);

    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom_range(0, 7)), pick_val(), pick_val(), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
